prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 167 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch controller feeding a DEPTH-entry FIFO.
// Optional macro PREFETCH_BYPASS_EN forwards an acked word straight to decode when the queue is empty.
module prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     f_enable,
    output logic [31:0]              f_addr,
    input  logic [31:0]              f_data,
    input  logic                     f_ack,
    output logic [31:0]              q_instr,
    output logic [31:0]              q_pc,
    output logic                     q_valid,
    input  logic                     q_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_SQUASH = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic           f_enable_q, f_enable_d;
    logic [31:0]    f_addr_q, f_addr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    instr_mem_q [DEPTH];
    logic [31:0]    pc_mem_q    [DEPTH];

    logic           push_c;
    logic           pop_c;
    logic           bypass_c;
    logic [31:0]    redirect_pc_c;

    assign redirect_pc_c = {redirect_pc[31:2], 2'b00};

    // Fetch controller next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f_enable_d = f_enable_q;
        f_addr_d   = f_addr_q;
        push_c     = 1'b0;
        bypass_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc_c;
                end else if (count_q < CW'(DEPTH)) begin
                    f_enable_d = 1'b1;
                    f_addr_d   = pc_q;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    pc_d = redirect_pc_c;
                    if (f_ack) begin
                        f_enable_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d    = S_SQUASH;
                    end
                end else if (f_ack) begin
                    push_c     = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    f_enable_d = 1'b0;
                    state_d    = S_IDLE;
`ifdef PREFETCH_BYPASS_EN
                    if (count_q == '0) begin
                        bypass_c = 1'b1;
                        // Word consumed directly by decode never enters storage
                        if (q_ready) push_c = 1'b0;
                    end
`endif
                end
            end
            S_SQUASH: begin
                if (redirect) pc_d = redirect_pc_c;
                if (f_ack) begin
                    f_enable_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                f_enable_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Queue pointer and occupancy; a redirect flush overrides push and pop
    always_comb begin
        pop_c    = (count_q != '0) && q_ready && !redirect;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            f_enable_q <= 1'b0;
            f_addr_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f_enable_q <= f_enable_d;
            f_addr_q   <= f_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty
    always_ff @(posedge clk) begin
        if (push_c && !redirect) begin
            instr_mem_q[wr_ptr_q] <= f_data;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    always_comb begin
        q_valid = (count_q != '0);
        q_instr = q_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
        q_pc    = q_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
        if (bypass_c) begin
            q_valid = 1'b1;
            q_instr = f_data;
            q_pc    = pc_q;
        end
    end

    assign f_enable = f_enable_q;
    assign f_addr   = f_addr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue (DEPTH=4, RESET_PC=0).
module tb_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        f_enable;
    logic [31:0] f_addr;
    logic [31:0] f_data;
    logic        f_ack;
    logic [31:0] q_instr;
    logic [31:0] q_pc;
    logic        q_valid;
    logic        q_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_enable   (f_enable),
        .f_addr     (f_addr),
        .f_data     (f_data),
        .f_ack      (f_ack),
        .q_instr    (q_instr),
        .q_pc       (q_pc),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request already visible; FETCH acks two cycles after the request edge
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] addr);
        check_eq("req_en", 32'(f_enable), 32'd1);
        check_eq("req_addr", f_addr, addr);
        tick();
        check_eq("addr_stable", f_addr, addr);
        f_ack  = 1'b1;
        f_data = data;
        tick();
        f_ack  = 1'b0;
        check_eq("en_drop", 32'(f_enable), 32'd0);
    endtask

    task automatic run_fetch(input logic [31:0] data, input logic [31:0] addr);
        tick();
        fetch_one(data, addr);
    endtask

    initial begin
        rst_n = 1'b0; f_ack = 1'b0; f_data = '0; q_ready = 1'b1;
        redirect = 1'b0; redirect_pc = '0;
        repeat (2) tick();
        check_eq("rst_en", 32'(f_enable), 32'd0);
        check_eq("rst_addr", f_addr, 32'h0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(q_valid), 32'd0);
        check_eq("rst_instr", q_instr, 32'h0);
        check_eq("rst_pc", q_pc, 32'h0);

        // Streaming with decode always ready: 0,4,8,C
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_fetch(32'hA000_0000 + 32'(i), 32'(4 * i));
            check_eq("s1_valid", 32'(q_valid), 32'd1);
            check_eq("s1_pc", q_pc, 32'(4 * i));
            check_eq("s1_instr", q_instr, 32'hA000_0000 + 32'(i));
            check_eq("s1_count", 32'(count), 32'd1);
        end

        // Reset while a request to 0x10 is outstanding, then a stray ack
        tick();
        check_eq("b_en", 32'(f_enable), 32'd1);
        check_eq("b_addr", f_addr, 32'h10);
        rst_n = 1'b0;
        #1;
        check_eq("b_rst_en", 32'(f_enable), 32'd0);
        check_eq("b_rst_addr", f_addr, 32'h0);
        check_eq("b_rst_count", 32'(count), 32'd0);
        tick();
        rst_n = 1'b1;
        f_ack = 1'b1; f_data = 32'hBAD0_0001;
        tick();
        f_ack = 1'b0;
        check_eq("b_first_en", 32'(f_enable), 32'd1);
        check_eq("b_first_addr", f_addr, 32'h0);
        check_eq("b_stray_count", 32'(count), 32'd0);
        check_eq("b_stray_valid", 32'(q_valid), 32'd0);

        // Decode stalled: fill to DEPTH, then a single pop frees one slot
        q_ready = 1'b0;
        fetch_one(32'h1000, 32'h0);
        for (int i = 1; i < 4; i++) run_fetch(32'h1000 + 32'(i), 32'(4 * i));
        check_eq("c_full", 32'(count), 32'd4);
        tick();
        check_eq("c_full_en", 32'(f_enable), 32'd0);
        check_eq("c_full_count", 32'(count), 32'd4);
        check_eq("c_head_pc", q_pc, 32'h0);
        check_eq("c_head_instr", q_instr, 32'h1000);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check_eq("c_pop_count", 32'(count), 32'd3);
        check_eq("c_pop_pc", q_pc, 32'h4);
        check_eq("c_pop_en", 32'(f_enable), 32'd0);
        tick();
        fetch_one(32'h1004, 32'h10);
        check_eq("c_refill", 32'(count), 32'd4);
        tick();
        check_eq("c_single_req", 32'(f_enable), 32'd0);

        // Redirect to 0x103 while fetching 0x8
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        q_ready = 1'b1;
        run_fetch(32'h2000, 32'h0);
        run_fetch(32'h2004, 32'h4);
        tick();
        check_eq("d_addr8", f_addr, 32'h8);
        check_eq("d_count0", 32'(count), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        check_eq("d_sq_en", 32'(f_enable), 32'd1);
        check_eq("d_sq_addr", f_addr, 32'h8);
        tick();
        f_ack = 1'b1; f_data = 32'h0000_0BAD;
        tick();
        f_ack = 1'b0;
        check_eq("d_discard_count", 32'(count), 32'd0);
        check_eq("d_discard_valid", 32'(q_valid), 32'd0);
        check_eq("d_discard_en", 32'(f_enable), 32'd0);
        tick();
        check_eq("d_new_en", 32'(f_enable), 32'd1);
        check_eq("d_new_addr", f_addr, 32'h100);

        // Redirect coincident with ack and pop
        q_ready = 1'b0;
        tick();
        f_ack = 1'b1; f_data = 32'h3000;
        tick();
        f_ack = 1'b0;
        check_eq("e_count1", 32'(count), 32'd1);
        tick();
        check_eq("e_addr", f_addr, 32'h104);
        tick();
        f_ack = 1'b1; f_data = 32'h3004;
        redirect = 1'b1; redirect_pc = 32'h200; q_ready = 1'b1;
        tick();
        f_ack = 1'b0; redirect = 1'b0;
        check_eq("e_count0", 32'(count), 32'd0);
        check_eq("e_valid0", 32'(q_valid), 32'd0);
        check_eq("e_en0", 32'(f_enable), 32'd0);
        tick();
        check_eq("e_new_en", 32'(f_enable), 32'd1);
        check_eq("e_new_addr", f_addr, 32'h200);

        // Ack into an empty queue with decode ready
        tick();
        f_ack = 1'b1; f_data = 32'hDEAD_BEEF;
        #1;
`ifdef PREFETCH_BYPASS_EN
        check_eq("f_byp_valid", 32'(q_valid), 32'd1);
        check_eq("f_byp_instr", q_instr, 32'hDEAD_BEEF);
        check_eq("f_byp_pc", q_pc, 32'h200);
`else
        check_eq("f_nobyp_valid", 32'(q_valid), 32'd0);
`endif
        tick();
        f_ack = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        check_eq("f_byp_count", 32'(count), 32'd0);
        check_eq("f_byp_after", 32'(q_valid), 32'd0);
`else
        check_eq("f_nobyp_count", 32'(count), 32'd1);
        check_eq("f_nobyp_instr", q_instr, 32'hDEAD_BEEF);
        check_eq("f_nobyp_pc", q_pc, 32'h200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
